// File: rtl/note_stabilizer.sv
// note_stabilizer: debounces the per-frame note index stream and emits one
// event per confirmed note change. Each event carries the new note and the
// length, in accepted frames, of the note it replaces. Prolonged input silence
// forces a commit of the rest note so a held note cannot hang forever.
module note_stabilizer #(
    parameter int NOTE_WIDTH     = 6,
    parameter int CONFIRM_COUNT  = 3,
    parameter int REST_NOTE      = 0,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NOTE_WIDTH-1:0] note_in,
    input  logic                  note_valid_in,
    output logic [NOTE_WIDTH-1:0] note_out,
    output logic                  note_valid_out,
    output logic [7:0]            dur_out,
    output logic                  active_out
);

    localparam logic [NOTE_WIDTH-1:0] REST    = NOTE_WIDTH'(REST_NOTE);
    localparam logic [3:0]            CONFIRM = 4'(CONFIRM_COUNT);
    localparam logic [23:0]           TIMEOUT = 24'(TIMEOUT_CYCLES);
    localparam logic [7:0]            DUR_MAX = 8'd255;

    // Tracking state: the note being confirmed, its run length, the note
    // last handed downstream, frames spent on that note, and silence length.
    logic [NOTE_WIDTH-1:0] cand_q, cand_d;
    logic [3:0]            cand_cnt_q, cand_cnt_d;
    logic [NOTE_WIDTH-1:0] committed_q, committed_d;
    logic [7:0]            hold_cnt_q, hold_cnt_d;
    logic [23:0]           idle_cnt_q, idle_cnt_d;

    // Registered outputs.
    logic [NOTE_WIDTH-1:0] note_q, note_d;
    logic                  valid_q, valid_d;
    logic [7:0]            dur_q, dur_d;
    logic                  active_q, active_d;

    // Scratch value: hold count including the frame accepted this cycle.
    logic [7:0]            hold_inc;

    // Next-state logic: an accepted frame updates the candidate and may
    // commit it; a silent cycle advances the idle timer and may force a rest.
    always_comb begin
        cand_d      = cand_q;
        cand_cnt_d  = cand_cnt_q;
        committed_d = committed_q;
        hold_cnt_d  = hold_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        note_d      = note_q;
        valid_d     = 1'b0;
        dur_d       = dur_q;
        hold_inc    = (hold_cnt_q == DUR_MAX) ? DUR_MAX : hold_cnt_q + 8'd1;

        if (note_valid_in) begin
            // Any valid frame restarts the silence timer, so it always
            // beats a timeout landing on the same cycle.
            idle_cnt_d = 24'd0;
            hold_cnt_d = hold_inc;

            if (note_in == cand_q) begin
                cand_cnt_d = (cand_cnt_q >= CONFIRM) ? CONFIRM : cand_cnt_q + 4'd1;
            end else begin
                cand_d     = note_in;
                cand_cnt_d = 4'd1;
            end

            // Commit only on the frame that reaches the threshold and only
            // when it actually changes the committed note; a saturated count
            // on the already-committed note therefore stays silent.
            if ((cand_cnt_d == CONFIRM) && (cand_d != committed_q)) begin
                note_d      = cand_d;
                dur_d       = hold_inc;
                valid_d     = 1'b1;
                committed_d = cand_d;
                hold_cnt_d  = 8'd0;
            end
        end else begin
            idle_cnt_d = (idle_cnt_q >= TIMEOUT) ? TIMEOUT : idle_cnt_q + 24'd1;

            // The timer saturates, so this fires once per silence; after it
            // fires the committed note is rest and the guard blocks repeats.
            if ((idle_cnt_d == TIMEOUT) && (committed_q != REST)) begin
                note_d      = REST;
                dur_d       = hold_cnt_q;
                valid_d     = 1'b1;
                committed_d = REST;
                hold_cnt_d  = 8'd0;
                cand_d      = REST;
                cand_cnt_d  = CONFIRM;
            end
        end

        active_d = (committed_d != REST);
    end

    // State and output registers with synchronous reset; a reset drops any
    // event that would have been issued on this edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cand_q      <= REST;
            cand_cnt_q  <= 4'd0;
            committed_q <= REST;
            hold_cnt_q  <= 8'd0;
            idle_cnt_q  <= 24'd0;
            note_q      <= REST;
            valid_q     <= 1'b0;
            dur_q       <= 8'd0;
            active_q    <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            cand_cnt_q  <= cand_cnt_d;
            committed_q <= committed_d;
            hold_cnt_q  <= hold_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            note_q      <= note_d;
            valid_q     <= valid_d;
            dur_q       <= dur_d;
            active_q    <= active_d;
        end
    end

    assign note_out       = note_q;
    assign note_valid_out = valid_q;
    assign dur_out        = dur_q;
    assign active_out     = active_q;

endmodule

// File: tb/tb_note_stabilizer.sv
// tb_note_stabilizer: directed bench for note_stabilizer with a short
// confirm threshold and timeout so every boundary is reachable quickly.
module tb_note_stabilizer;

    localparam int NW = 6;

    logic          clk_in;
    logic          rst_in;
    logic [NW-1:0] note_in;
    logic          note_valid_in;
    logic [NW-1:0] note_out;
    logic          note_valid_out;
    logic [7:0]    dur_out;
    logic          active_out;

    int compared;
    int mismatched;

    note_stabilizer #(
        .NOTE_WIDTH     (NW),
        .CONFIRM_COUNT  (3),
        .REST_NOTE      (0),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .note_in        (note_in),
        .note_valid_in  (note_valid_in),
        .note_out       (note_out),
        .note_valid_out (note_valid_out),
        .dur_out        (dur_out),
        .active_out     (active_out)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Drive one cycle of inputs, then move to #1 after the edge so the
    // registered outputs produced by that edge are stable for checking.
    task automatic applyStimulus(input logic rst, input logic vld, input logic [NW-1:0] note);
        rst_in        = rst;
        note_valid_in = vld;
        note_in       = note;
        @(posedge clk_in);
        #1;
    endtask

    // Compare all four outputs at once against hand-computed values.
    task automatic checkOutput(input string tag, input logic [NW-1:0] exp_note,
                               input logic exp_valid, input logic [7:0] exp_dur,
                               input logic exp_active);
        logic [15:0] observed;
        logic [15:0] expected;
        observed = {note_out, note_valid_out, dur_out, active_out};
        expected = {exp_note, exp_valid, exp_dur, exp_active};
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed note=%0d valid=%0d dur=%0d active=%0d expected note=%0d valid=%0d dur=%0d active=%0d",
                   tag, note_out, note_valid_out, dur_out, active_out,
                   exp_note, exp_valid, exp_dur, exp_active);
        end
    endtask

    // Hold reset with live random input and confirm outputs stay at reset.
    task automatic resetDut(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b1, 1'b1, NW'($urandom));
            checkOutput("reset", 6'd0, 1'b0, 8'd0, 1'b0);
        end
    endtask

    // Feed 5,5,5 from reset and check the single commit event.
    task automatic commitFive();
        applyStimulus(1'b0, 1'b1, 6'd5);
        checkOutput("commit5_a", 6'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'd5);
        checkOutput("commit5_b", 6'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'd5);
        checkOutput("commit5_pulse", 6'd5, 1'b1, 8'd3, 1'b1);
    endtask

    initial begin
        logic [NW-1:0] glitch [7];
        compared      = 0;
        mismatched    = 0;
        rst_in        = 1'b1;
        note_valid_in = 1'b0;
        note_in       = '0;

        // Reset with random input activity.
        resetDut(3);

        // Basic commit, then one silent cycle: strobe must drop, data held.
        commitFive();
        applyStimulus(1'b0, 1'b0, 6'd0);
        checkOutput("basic_after", 6'd5, 1'b0, 8'd3, 1'b1);

        // Glitch rejection: none of these runs reaches three in a row.
        glitch = '{6'd5, 6'd7, 6'd5, 6'd5, 6'd9, 6'd9, 6'd5};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, glitch[i]);
            checkOutput("glitch", 6'd5, 1'b0, 8'd3, 1'b1);
        end

        // Duration: 5 committed, ten more 5s, then 9,9,9 -> dur 13.
        resetDut(1);
        commitFive();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 6'd5);
            checkOutput("dur_hold5", 6'd5, 1'b0, 8'd3, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 6'd9);
        checkOutput("dur_9a", 6'd5, 1'b0, 8'd3, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd9);
        checkOutput("dur_9b", 6'd5, 1'b0, 8'd3, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd9);
        checkOutput("dur_9_pulse", 6'd9, 1'b1, 8'd13, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd0);
        checkOutput("dur_0a", 6'd9, 1'b0, 8'd13, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd0);
        checkOutput("dur_0b", 6'd9, 1'b0, 8'd13, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd0);
        checkOutput("dur_rest_pulse", 6'd0, 1'b1, 8'd3, 1'b0);

        // Timeout: pulse lands on the 100th silent edge, then never again.
        resetDut(1);
        commitFive();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 6'd5);
            checkOutput("to_hold5", 6'd5, 1'b0, 8'd3, 1'b1);
        end
        for (int i = 1; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 6'd0);
            checkOutput("to_waiting", 6'd5, 1'b0, 8'd3, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 6'd0);
        checkOutput("to_pulse", 6'd0, 1'b1, 8'd4, 1'b0);
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'b0, 1'b0, 6'd0);
            checkOutput("to_silence", 6'd0, 1'b0, 8'd4, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 6'd0);
            checkOutput("to_rest_again", 6'd0, 1'b0, 8'd4, 1'b0);
        end

        // Saturation: 300 extra frames clamp the duration at 255.
        resetDut(1);
        commitFive();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 6'd5);
        end
        checkOutput("sat_held", 6'd5, 1'b0, 8'd3, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd9);
        applyStimulus(1'b0, 1'b1, 6'd9);
        checkOutput("sat_9b", 6'd5, 1'b0, 8'd3, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd9);
        checkOutput("sat_pulse", 6'd9, 1'b1, 8'd255, 1'b1);

        // Mid-run reset discards the half-confirmed 6 candidate.
        applyStimulus(1'b0, 1'b1, 6'd6);
        checkOutput("mid_6a", 6'd9, 1'b0, 8'd255, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd6);
        checkOutput("mid_6b", 6'd9, 1'b0, 8'd255, 1'b1);
        applyStimulus(1'b1, 1'b0, 6'd0);
        checkOutput("mid_reset", 6'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'd6);
        checkOutput("post_6a", 6'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'd6);
        checkOutput("post_6b", 6'd0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 6'd6);
        checkOutput("post_6_pulse", 6'd6, 1'b1, 8'd3, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd6);
        checkOutput("post_6_quiet", 6'd6, 1'b0, 8'd3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
